uart_tx_param: RTL and testbench

//   Parametrised successor to the fixed 8N1 UART transmitter. Serialises words from a

---
 rtl/uart_tx_param_if.sv | 21 ++
 rtl/uart_tx_param.sv | 215 +++++++++++++++++++++
 tb/tb_uart_tx_param.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_param_if.sv
// Valid/ready word stream into the UART transmitter FIFO.
// Source side drives valid/data, transmitter returns ready.
interface uart_tx_param_if #(
    parameter int DATA_W = 8
);
    logic              s_valid;
    logic [DATA_W-1:0] s_data;
    logic              s_ready;

    modport master (
        output s_valid,
        output s_data,
        input  s_ready
    );

    modport slave (
        input  s_valid,
        input  s_data,
        output s_ready
    );
endinterface

// File: rtl/uart_tx_param.sv
// UART transmitter with runtime baud divisor, parity and stop bits.
// Words queue in a small FIFO; frames go out LSB first, back-to-back.
module uart_tx_param #(
    parameter int DATA_W     = 8,
    parameter int DIV_W      = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [DIV_W-1:0]            baud_div,
    input  logic [1:0]                  parity_mode,
    input  logic                        stop2,
    uart_tx_param_if.slave              s,
    output logic                        txd,
    output logic                        busy,
    output logic                        tx_done,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int BW = $clog2(DATA_W);
    localparam logic [LW-1:0] FULL     = LW'(FIFO_DEPTH);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]     r_wptr;
    logic [AW-1:0]     r_rptr;
    logic [LW-1:0]     r_level;

    logic              w_ready;
    logic              w_push;
    logic              w_pop;
    logic              w_has;
    logic [DATA_W-1:0] w_head;

    state_t            r_state;
    state_t            w_state_nx;
    logic [DIV_W-1:0]  r_cnt;
    logic [DIV_W-1:0]  w_cnt_nx;
    logic [BW-1:0]     r_bit;
    logic [BW-1:0]     w_bit_nx;
    logic              r_stc;
    logic              w_stc_nx;
    logic [DATA_W-1:0] r_shift;
    logic [DATA_W-1:0] w_shift_nx;
    logic              r_txd;
    logic              w_txd_nx;
    logic              w_done;
    logic              w_bit_end;

    // Frame settings captured at pop time, stable for the whole frame
    logic [DIV_W-1:0]  r_div;
    logic              r_pen;
    logic              r_par;
    logic              r_stop2;

    assign w_ready = (r_level != FULL);
    assign w_push  = s.s_valid && w_ready;
    assign w_has   = (r_level != '0);
    assign w_head  = r_mem[r_rptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= s.s_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    assign w_bit_end = (r_cnt == r_div);

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt + 1'b1;
        w_bit_nx   = r_bit;
        w_stc_nx   = r_stc;
        w_shift_nx = r_shift;
        w_txd_nx   = r_txd;
        w_pop      = 1'b0;
        w_done     = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt_nx = '0;
                w_txd_nx = 1'b1;
                if (w_has) begin
                    w_pop      = 1'b1;
                    w_state_nx = S_START;
                    w_txd_nx   = 1'b0;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_cnt_nx   = '0;
                    w_bit_nx   = '0;
                    w_state_nx = S_DATA;
                    w_txd_nx   = r_shift[0];
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    w_cnt_nx = '0;
                    if (r_bit == LAST_BIT) begin
                        w_stc_nx = 1'b0;
                        if (r_pen) begin
                            w_state_nx = S_PARITY;
                            w_txd_nx   = r_par;
                        end else begin
                            w_state_nx = S_STOP;
                            w_txd_nx   = 1'b1;
                        end
                    end else begin
                        w_bit_nx   = r_bit + 1'b1;
                        w_shift_nx = r_shift >> 1;
                        w_txd_nx   = r_shift[1];
                    end
                end
            end
            S_PARITY: begin
                if (w_bit_end) begin
                    w_cnt_nx   = '0;
                    w_stc_nx   = 1'b0;
                    w_state_nx = S_STOP;
                    w_txd_nx   = 1'b1;
                end
            end
            S_STOP: begin
                if (w_bit_end) begin
                    w_cnt_nx = '0;
                    if (r_stc == r_stop2) begin
                        w_done = 1'b1;
                        // Chain straight into the next start bit when queued
                        if (w_has) begin
                            w_pop      = 1'b1;
                            w_state_nx = S_START;
                            w_txd_nx   = 1'b0;
                        end else begin
                            w_state_nx = S_IDLE;
                            w_txd_nx   = 1'b1;
                        end
                    end else begin
                        w_stc_nx = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nx = S_IDLE;
                w_cnt_nx   = '0;
                w_txd_nx   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_stc   <= 1'b0;
            r_shift <= '0;
            r_txd   <= 1'b1;
            r_div   <= '0;
            r_pen   <= 1'b0;
            r_par   <= 1'b0;
            r_stop2 <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_bit   <= w_bit_nx;
            r_stc   <= w_stc_nx;
            r_txd   <= w_txd_nx;
            if (w_pop) begin
                r_shift <= w_head;
                r_div   <= baud_div;
                r_pen   <= (parity_mode == 2'b01) ||
                           (parity_mode == 2'b10);
                r_par   <= (^w_head) ^ (parity_mode == 2'b10);
                r_stop2 <= stop2;
            end else begin
                r_shift <= w_shift_nx;
            end
        end
    end

    assign s.s_ready  = w_ready;
    assign txd        = r_txd;
    assign tx_done    = w_done;
    assign busy       = (r_state != S_IDLE) || w_has;
    assign fifo_level = r_level;
endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param.
// A negedge frame decoder collects sent frames for comparison.
module tb_uart_tx_param;
    logic        clk;
    logic        reset;
    logic [15:0] baud_div;
    logic [1:0]  parity_mode;
    logic        stop2;
    logic        txd;
    logic        busy;
    logic        tx_done;
    logic [2:0]  fifo_level;

    uart_tx_param_if #(.DATA_W(8)) s_if ();

    uart_tx_param #(
        .DATA_W(8),
        .DIV_W(16),
        .FIFO_DEPTH(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .baud_div(baud_div),
        .parity_mode(parity_mode),
        .stop2(stop2),
        .s(s_if),
        .txd(txd),
        .busy(busy),
        .tx_done(tx_done),
        .fifo_level(fifo_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int n_done = 0;

    int q_frame [$];
    int q_dn    [$];
    int q_gl    [$];
    int q_gap   [$];

    int          m_per   = 4;
    int          m_nbits = 10;
    bit          m_in    = 0;
    bit          m_gl;
    int          m_c;
    int          m_b;
    int          m_dn;
    int          m_gap   = 0;
    int          ml_per;
    int          ml_nb;
    logic [15:0] m_cur;

    // Frame decoder: bits taken at the first clock of each period,
    // later clocks of the same period must hold the same level
    always @(negedge clk) begin
        if (tx_done === 1'b1) n_done++;
        if (reset) begin
            m_in  = 0;
            m_gap = 0;
        end else begin
            if (!m_in && txd === 1'b0) begin
                m_in   = 1;
                m_c    = 0;
                ml_per = m_per;
                ml_nb  = m_nbits;
                m_cur  = '0;
                m_gl   = 0;
                m_dn   = 0;
                q_gap.push_back(m_gap);
                m_gap  = 0;
            end
            if (m_in) begin
                m_c++;
                m_b = (m_c - 1) / ml_per;
                if ((m_c - 1) % ml_per == 0) m_cur[m_b] = txd;
                else if (txd !== m_cur[m_b]) m_gl = 1;
                if (tx_done === 1'b1 && m_dn == 0) m_dn = m_c;
                if (m_c == ml_nb * ml_per) begin
                    q_frame.push_back(int'(m_cur));
                    q_dn.push_back(m_dn);
                    q_gl.push_back(int'(m_gl));
                    m_in = 0;
                end
            end else begin
                m_gap++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic push1(input logic [7:0] d);
        s_if.s_valid = 1'b1;
        s_if.s_data  = d;
        tick();
        s_if.s_valid = 1'b0;
    endtask

    task automatic wait_frames(input int n, input int lim, input string tag);
        int t;
        t = 0;
        while (q_frame.size() < n && t < lim) begin
            tick();
            t++;
        end
        chk(tag, q_frame.size(), n);
    endtask

    task automatic clr_q();
        q_frame.delete();
        q_dn.delete();
        q_gl.delete();
        q_gap.delete();
    endtask

    int          waited;
    int          done_snap;
    logic [31:0] exp4 [6];
    logic [7:0]  w4   [6];

    initial begin
        w4   = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        exp4 = '{32'h222, 32'h244, 32'h266, 32'h288, 32'h2AA, 32'h2CC};

        reset        = 1'b1;
        baud_div     = 16'd3;
        parity_mode  = 2'b00;
        stop2        = 1'b0;
        s_if.s_valid = 1'b0;
        s_if.s_data  = '0;
        tick();
        tick();
        chk("rst_txd", txd, 1);
        chk("rst_done", tx_done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_ready", s_if.s_ready, 1);
        reset = 1'b0;
        tick();

        // 8N1, divisor 3, 0xA5
        clr_q();
        m_per = 4; m_nbits = 10;
        push1(8'hA5);
        chk("t1_level_push", fifo_level, 1);
        chk("t1_busy", busy, 1);
        chk("t1_txd_before", txd, 1);
        tick();
        chk("t1_txd_fall", txd, 0);
        chk("t1_level_pop", fifo_level, 0);
        wait_frames(1, 80, "t1_frames");
        chk("t1_frame", q_frame[0], 32'h34A);
        chk("t1_done_at", q_dn[0], 40);
        chk("t1_hold", q_gl[0], 0);
        tick();
        chk("t1_idle_busy", busy, 0);
        chk("t1_idle_txd", txd, 1);

        // Even then odd parity on 0x07, divisor 1
        clr_q();
        baud_div = 16'd1; parity_mode = 2'b01;
        m_per = 2; m_nbits = 11;
        push1(8'h07);
        wait_frames(1, 60, "t2_even_frames");
        chk("t2_even_frame", q_frame[0], 32'h60E);
        chk("t2_even_done", q_dn[0], 22);
        tick();
        parity_mode = 2'b10;
        push1(8'h07);
        wait_frames(2, 60, "t2_odd_frames");
        chk("t2_odd_frame", q_frame[1], 32'h40E);
        chk("t2_odd_done", q_dn[1], 22);
        tick();

        // Two stop bits, one clock per bit, back-to-back
        clr_q();
        baud_div = 16'd0; parity_mode = 2'b00; stop2 = 1'b1;
        m_per = 1; m_nbits = 11;
        s_if.s_valid = 1'b1;
        s_if.s_data  = 8'h00;
        tick();
        s_if.s_data  = 8'hFF;
        tick();
        s_if.s_valid = 1'b0;
        chk("t3_level_pushpop", fifo_level, 1);
        chk("t3_txd_start", txd, 0);
        wait_frames(2, 60, "t3_frames");
        chk("t3_frame0", q_frame[0], 32'h600);
        chk("t3_frame1", q_frame[1], 32'h7FE);
        chk("t3_done0", q_dn[0], 11);
        chk("t3_done1", q_dn[1], 11);
        chk("t3_gap", q_gap[1], 0);
        tick();

        // Six words held on valid, divisor 9, FIFO fills up
        clr_q();
        baud_div = 16'd9; stop2 = 1'b0;
        m_per = 10; m_nbits = 10;
        s_if.s_valid = 1'b1;
        s_if.s_data  = w4[0];
        tick();
        chk("t4_lvl0", fifo_level, 1);
        s_if.s_data = w4[1];
        tick();
        chk("t4_lvl1", fifo_level, 1);
        s_if.s_data = w4[2];
        tick();
        chk("t4_lvl2", fifo_level, 2);
        s_if.s_data = w4[3];
        tick();
        chk("t4_lvl3", fifo_level, 3);
        s_if.s_data = w4[4];
        tick();
        chk("t4_lvl4", fifo_level, 4);
        chk("t4_full_ready", s_if.s_ready, 0);
        s_if.s_data = w4[5];
        waited = 0;
        while (!s_if.s_ready && waited < 300) begin
            tick();
            waited++;
        end
        chk("t4_ready_wait", waited, 97);
        chk("t4_lvl_drain", fifo_level, 3);
        tick();
        s_if.s_valid = 1'b0;
        chk("t4_lvl_refill", fifo_level, 4);
        wait_frames(6, 700, "t4_frames");
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("t4_frame%0d", i), q_frame[i], exp4[i]);
        end
        tick();
        chk("t4_empty", fifo_level, 0);
        chk("t4_busy", busy, 0);

        // Settings changed mid-frame apply only to the next frame
        clr_q();
        push1(8'h3C);
        repeat (30) tick();
        baud_div = 16'd1; parity_mode = 2'b01;
        m_per = 2; m_nbits = 11;
        push1(8'h3C);
        wait_frames(2, 200, "t5_frames");
        chk("t5_frame_old", q_frame[0], 32'h278);
        chk("t5_done_old", q_dn[0], 100);
        chk("t5_hold_old", q_gl[0], 0);
        chk("t5_frame_new", q_frame[1], 32'h478);
        chk("t5_done_new", q_dn[1], 22);
        chk("t5_gap", q_gap[1], 0);
        tick();

        // Reset during data bits of the second of three frames
        clr_q();
        baud_div = 16'd3; parity_mode = 2'b00;
        m_per = 4; m_nbits = 10;
        s_if.s_valid = 1'b1;
        s_if.s_data  = 8'h81;
        tick();
        s_if.s_data  = 8'h00;
        tick();
        s_if.s_data  = 8'hC3;
        tick();
        s_if.s_valid = 1'b0;
        wait_frames(1, 100, "t6_first");
        repeat (10) tick();
        chk("t6_pre_txd", txd, 0);
        chk("t6_pre_level", fifo_level, 1);
        done_snap = n_done;
        reset = 1'b1;
        #1;
        chk("t6_rst_txd", txd, 1);
        chk("t6_rst_level", fifo_level, 0);
        chk("t6_rst_busy", busy, 0);
        tick();
        reset = 1'b0;
        repeat (60) tick();
        chk("t6_no_done", n_done, done_snap);
        chk("t6_no_frame", q_frame.size(), 1);
        chk("t6_idle_txd", txd, 1);
        push1(8'h5A);
        wait_frames(2, 80, "t6_fresh");
        chk("t6_fresh_frame", q_frame[1], 32'h2B4);
        chk("t6_fresh_done", q_dn[1], 40);
        chk("t6_fresh_hold", q_gl[1], 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
